// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: state encoding and
// the owner-index width helper.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY,
        S_RESP = ST_RESP
    } arb_state_e;

    // Width of a port index; never below one bit so a 1- or 2-port build still has a port.
    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request bit at or after
// ptr (wrapping modulo NUM_PORTS) wins.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int OW        = owner_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [OW-1:0]        ptr,
    output logic [OW-1:0]        winner,
    output logic                 valid
);

    logic [NUM_PORTS-1:0][OW-1:0] cand;

    // Candidate index for each search offset, wrapped into 0..NUM_PORTS-1.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (int'(ptr) + k >= NUM_PORTS)
                cand[k] = OW'(int'(ptr) + k - NUM_PORTS);
            else
                cand[k] = OW'(int'(ptr) + k);
        end
    end

    // Scan farthest offset first so the nearest requester overrides it.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                winner = cand[k];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among NUM_PORTS requesters. A winner's request
// is latched and held downstream until mem_ready, then the read data is
// returned with a one-cycle m_done pulse to that requester.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    localparam int OW       = owner_w(NUM_PORTS),
    localparam int BE_W     = DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        m_req,
    input  logic [NUM_PORTS*ADDR_W-1:0] m_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] m_wdata,
    input  logic [NUM_PORTS*BE_W-1:0]   m_be,
    input  logic [NUM_PORTS-1:0]        m_we,
    output logic [NUM_PORTS-1:0]        m_done,
    output logic [DATA_W-1:0]           m_rdata,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic [BE_W-1:0]             mem_be,
    output logic                        mem_we,
    input  logic                        mem_ready,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [OW-1:0]               owner
);

    arb_state_e state;
    logic [OW-1:0] rr_ptr;
    logic [OW-1:0] win;
    logic [OW-1:0] win_next;
    logic          win_vld;
    logic [NUM_PORTS-1:0] own_oh;

    // Per-port views of the flattened request buses.
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_v;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_v;
    logic [NUM_PORTS-1:0][BE_W-1:0]   be_v;

    assign addr_v  = m_addr;
    assign wdata_v = m_wdata;
    assign be_v    = m_be;

    rr_pick #(
        .NUM_PORTS(NUM_PORTS),
        .OW       (OW)
    ) u_pick (
        .req   (m_req),
        .ptr   (rr_ptr),
        .winner(win),
        .valid (win_vld)
    );

    assign win_next = (win == OW'(NUM_PORTS - 1)) ? '0 : win + OW'(1);
    assign own_oh   = {{(NUM_PORTS-1){1'b0}}, 1'b1} << owner;

    // Arbitration FSM with the request latch, response register and rr pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            mem_we    <= 1'b0;
            m_done    <= '0;
            m_rdata   <= '0;
        end else begin
            m_done <= '0;
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        mem_addr  <= addr_v[win];
                        mem_wdata <= wdata_v[win];
                        mem_be    <= be_v[win];
                        mem_we    <= m_we[win];
                        owner     <= win;
                        rr_ptr    <= win_next;
                        mem_req   <= 1'b1;
                        state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Writes also capture mem_rdata; the requester ignores it.
                    if (mem_ready) begin
                        m_rdata <= mem_rdata;
                        mem_req <= 1'b0;
                        m_done  <= own_oh;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (4 ports): directed scenarios with literal
// expectations plus a randomized phase, all cross-checked every cycle
// against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int OW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    m_req, m_we, m_done;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*BW-1:0] m_be;
    logic [DW-1:0]   m_rdata, mem_wdata, mem_rdata;
    logic            mem_req, mem_we, mem_ready;
    logic [AW-1:0]   mem_addr;
    logic [BW-1:0]   mem_be;
    logic [OW-1:0]   owner;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_be     (m_be),
        .m_we     (m_we),
        .m_done   (m_done),
        .m_rdata  (m_rdata),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_we   (mem_we),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .owner    (owner)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transaction is either absent, waiting for mem_ready, or reporting
    // completion; the winner is the first requester found scanning upward
    // from the port after the previous winner.
    bit            md_busy, md_resp;
    int            md_owner, md_rr, w;
    logic [AW-1:0] md_addr;
    logic [DW-1:0] md_wdata, md_rdata;
    logic [BW-1:0] md_be;
    logic          md_we;
    logic [N-1:0]  md_done;

    always @(posedge clk) begin
        if (!rst_n) begin
            md_busy = 0; md_resp = 0; md_owner = 0; md_rr = 0;
            md_addr = '0; md_wdata = '0; md_be = '0; md_we = 1'b0;
            md_done = '0; md_rdata = '0;
        end else if (md_resp) begin
            md_resp = 0;
            md_done = '0;
        end else if (md_busy) begin
            if (mem_ready) begin
                md_rdata = mem_rdata;
                md_busy  = 0;
                md_resp  = 1;
                md_done  = '0;
                md_done[md_owner] = 1'b1;
            end
        end else begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && m_req[(md_rr + k) % N]) w = (md_rr + k) % N;
            if (w >= 0) begin
                md_owner = w;
                md_rr    = (w + 1) % N;
                md_addr  = m_addr[w*AW +: AW];
                md_wdata = m_wdata[w*DW +: DW];
                md_be    = m_be[w*BW +: BW];
                md_we    = m_we[w];
                md_busy  = 1;
            end
        end
        #1;
        chk("mem_req",   mem_req,   md_busy);
        chk("m_done",    m_done,    md_done);
        chk("m_rdata",   m_rdata,   md_rdata);
        chk("owner",     owner,     md_owner);
        chk("mem_addr",  mem_addr,  md_addr);
        chk("mem_wdata", mem_wdata, md_wdata);
        chk("mem_be",    mem_be,    md_be);
        chk("mem_we",    mem_we,    md_we);
        if (mem_req && m_done != '0) chk("req_and_done", 1'b1, 1'b0);
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req(input string name, input int exp_owner);
        int n = 0;
        while (!mem_req && n < 20) begin tick(); n++; end
        chk({name, "_req"}, mem_req, 1'b1);
        chk({name, "_owner"}, owner, exp_owner);
    endtask

    task automatic wait_done(input string name, input logic [N-1:0] exp);
        int n = 0;
        while (m_done == '0 && n < 30) begin tick(); n++; end
        chk({name, "_done"}, m_done, exp);
    endtask

    int seq[6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        rst_n = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_be = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        chk("reset_mem_req", mem_req, 1'b0);
        chk("reset_done", m_done, 4'b0000);
        chk("reset_owner", owner, 2'd0);
        chk("reset_rdata", m_rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        // single read, port 0
        m_req[0] = 1'b1; m_addr[0 +: AW] = 32'h100; m_we[0] = 1'b0; m_be[0 +: BW] = 4'hF;
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("rd_busy_req", mem_req, 1'b1);
        chk("rd_addr", mem_addr, 32'h100);
        chk("rd_done_early", m_done, 4'b0000);
        tick();
        chk("rd_done", m_done, 4'b0001);
        chk("rd_rdata", m_rdata, 32'hDEADBEEF);
        chk("rd_req_drop", mem_req, 1'b0);
        m_req[0] = 1'b0;
        tick();
        chk("rd_done_clear", m_done, 4'b0000);

        // write with wait states, port 1
        m_req[1] = 1'b1; m_addr[AW +: AW] = 32'h200; m_wdata[DW +: DW] = 32'h55AA55AA;
        m_be[BW +: BW] = 4'b0011; m_we[1] = 1'b1; mem_ready = 1'b0; mem_rdata = 32'h12345678;
        tick();
        m_addr[AW +: AW] = 32'hBAD0; m_wdata[DW +: DW] = 32'h0; m_we[1] = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            chk("ws_req", mem_req, 1'b1);
            chk("ws_addr", mem_addr, 32'h200);
            chk("ws_wdata", mem_wdata, 32'h55AA55AA);
            chk("ws_be", mem_be, 4'b0011);
            chk("ws_we", mem_we, 1'b1);
            chk("ws_done", m_done, 4'b0000);
            if (b == 5) mem_ready = 1'b1;
            tick();
        end
        chk("ws_done_cycle7", m_done, 4'b0010);
        m_req[1] = 1'b0;

        // fairness from rr_ptr = 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_we = '0;
        m_req = 4'b0011; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_req("fair", seq[i]);
            wait_done("fair", 4'b0001 << seq[i]);
        end
        m_req = '0;

        // withdrawal mid-transaction
        mem_ready = 1'b0;
        m_req[0] = 1'b1;
        wait_req("wd", 0);
        tick();
        m_req[0] = 1'b0;
        tick();
        mem_ready = 1'b1;
        wait_done("wd", 4'b0001);

        // reset during BUSY
        mem_ready = 1'b0;
        m_req[2] = 1'b1; m_addr[2*AW +: AW] = 32'h300;
        wait_req("rst", 2);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_req", mem_req, 1'b0);
        chk("rst_mid_done", m_done, 4'b0000);
        chk("rst_mid_owner", owner, 2'd0);
        chk("rst_mid_addr", mem_addr, 32'h0);
        rst_n = 1'b1;
        m_req = 4'b1001; mem_ready = 1'b1;
        wait_req("rst_next", 0);
        wait_done("rst_next", 4'b0001);
        m_req = '0;

        // wrap: get rr_ptr to 3, then ports 3 and 0 compete
        m_req = 4'b0100;
        wait_req("wrap_pre", 2);
        wait_done("wrap_pre", 4'b0100);
        m_req = 4'b1001;
        wait_req("wrap_p3", 3);
        wait_done("wrap_p3", 4'b1000);
        m_req[3] = 1'b0;
        wait_req("wrap_p0", 0);
        wait_done("wrap_p0", 4'b0001);
        m_req = 4'b1111;
        wait_req("wrap_p1", 1);
        wait_done("wrap_p1", 4'b0010);
        m_req = '0;
        tick();

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < N; p++) begin
                if (m_req[p]) m_req[p] = ($urandom_range(0, 7) != 0);
                else          m_req[p] = ($urandom_range(0, 2) == 0);
                m_addr[p*AW +: AW]  = $urandom;
                m_wdata[p*DW +: DW] = $urandom;
                m_be[p*BW +: BW]    = BW'($urandom);
                m_we[p]             = 1'($urandom);
            end
            mem_ready = ($urandom_range(0, 2) != 0);
            mem_rdata = $urandom;
            rst_n     = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1'b1;
        m_req = '0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
